// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle RV32I core: one datapath step per clock
// per instruction class, stalling on a single-outstanding memory handshake.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_ALUWB    = 4'd8,
        S_EXECI    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state_q, state_d;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        retire     = 1'b0;
        illegal    = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;

        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase

        case (state_q)
            S_RESET: begin
                imm_src = 2'b00;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <- oldPC + imm, the branch/jump target used later
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_we  = mem_ready;
                retire  = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC <- target in ALUOut while the ALU forms oldPC+4 for the link
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                imm_src = 2'b00;
                illegal = 1'b1;
            end
            default: begin
                imm_src = 2'b00;
                state_d = S_RESET;
            end
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instructions expand into per-cycle
// expected output records that one loop drives and compares every cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, retire, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .imm_src(imm_src), .retire(retire), .illegal(illegal)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr;
        logic       ir;
        logic       pcw;
        logic       rw;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aluop;
        logic [1:0] rsrc;
        logic [1:0] imm;
        logic       retire;
        logic       illegal;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic       zero;
        out_t       o;
        string      name;
    } exp_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    exp_t r;
    exp_t q[$];
    int   cpi[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic out_t dut_out();
        out_t g;
        g = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
             alu_src_b, alu_op, result_src, imm_src, retire, illegal};
        return g;
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b required=%b", name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Fresh record: inputs outside the handshake are randomised since they must not matter.
    task automatic clr(input logic [6:0] op, input string name);
        r = '{op: op, rdy: 1'($urandom_range(0, 1)), zero: 1'($urandom_range(0, 1)),
              o: '0, name: name};
        r.o.imm = imm_of(op);
    endtask

    task automatic put();
        q.push_back(r);
    endtask

    task automatic push_reset();
        clr(RT, "RESET");
        r.o.imm = 2'b00;
        put();
    endtask

    task automatic fetch(input logic [6:0] op, input int st);
        for (int i = 0; i <= st; i++) begin
            clr(op, "FETCH");
            r.rdy = (i == st);
            r.o.mem_req = 1'b1;
            r.o.b = 2'b10;
            r.o.rsrc = 2'b10;
            r.o.ir = (i == st);
            r.o.pcw = (i == st);
            put();
        end
    endtask

    task automatic mem_access(input logic [6:0] op, input string name, input int st,
                              input bit wr);
        for (int i = 0; i <= st; i++) begin
            clr(op, name);
            r.rdy = (i == st);
            r.o.mem_req = 1'b1;
            r.o.adr = 1'b1;
            if (wr && i == st) begin
                r.o.mem_we = 1'b1;
                r.o.retire = 1'b1;
            end
            put();
        end
    endtask

    task automatic writeback(input logic [6:0] op, input string name, input logic [1:0] rsrc);
        clr(op, name);
        r.o.rw = 1'b1;
        r.o.retire = 1'b1;
        r.o.rsrc = rsrc;
        put();
    endtask

    task automatic alu_step(input logic [6:0] op, input string name, input logic [1:0] a,
                            input logic [1:0] b, input logic [1:0] aluop);
        clr(op, name);
        r.o.a = a;
        r.o.b = b;
        r.o.aluop = aluop;
        put();
    endtask

    // Expand one instruction into its expected cycle sequence.
    task automatic instr(input logic [6:0] op, input int st_f, input int st_m, input logic z);
        fetch(op, st_f);
        alu_step(op, "DECODE", 2'b01, 2'b01, 2'b00);
        if (op == LW || op == SW) begin
            alu_step(op, "MEMADR", 2'b10, 2'b01, 2'b00);
            if (op == LW) begin
                mem_access(op, "MEMREAD", st_m, 1'b0);
                writeback(op, "MEMWB", 2'b01);
            end else begin
                mem_access(op, "MEMWRITE", st_m, 1'b1);
            end
        end else if (op == RT || op == IT) begin
            alu_step(op, "EXEC", 2'b10, (op == IT) ? 2'b01 : 2'b00, 2'b10);
            writeback(op, "ALUWB", 2'b00);
        end else if (op == JL) begin
            alu_step(op, "JAL", 2'b01, 2'b10, 2'b00);
            r.o.pcw = 1'b1;
            q[$] = r;
            writeback(op, "ALUWB", 2'b00);
        end else if (op == BQ) begin
            alu_step(op, "BEQ", 2'b10, 2'b00, 2'b01);
            r.zero = z;
            r.o.pcw = z;
            r.o.retire = 1'b1;
            q[$] = r;
        end else begin
            for (int i = 0; i < 12; i++) begin
                clr(op, "TRAP");
                r.o.imm = 2'b00;
                r.o.illegal = 1'b1;
                put();
            end
        end
    endtask

    // Drive each record just after a falling edge, compare, and advance one clock.
    task automatic run_q();
        exp_t e;
        out_t g;
        while (q.size() > 0) begin
            e = q.pop_front();
            opcode = e.op;
            mem_ready = e.rdy;
            zero = e.zero;
            #1;
            g = dut_out();
            check(e.name, g, e.o);
            if (e.name != "RESET") cyc++;
            if (g.retire) begin
                cpi.push_back(cyc);
                cyc = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic async_reset(input string name);
        mem_ready = 1'b1;
        zero = 1'b1;
        #2 rst_n = 1'b0;
        #1 check(name, dut_out(), '0);
        @(posedge clk);
        #1 check({name, "_HELD"}, dut_out(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int exp_cpi[10];
        exp_cpi = '{4, 7, 5, 3, 3, 5, 4, 4, 4, 6};

        opcode = SW;
        mem_ready = 1'b1;
        #3 check("RST_HOLD", dut_out(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        push_reset();
        instr(RT, 0, 0, 1'b0);
        instr(LW, 0, 2, 1'b0);
        instr(LW, 0, 0, 1'b0);
        instr(BQ, 0, 0, 1'b1);
        instr(BQ, 0, 0, 1'b0);
        instr(SW, 0, 1, 1'b0);
        instr(IT, 0, 0, 1'b0);
        instr(JL, 0, 0, 1'b0);
        instr(SW, 0, 0, 1'b0);
        instr(RT, 2, 0, 1'b0);
        instr(BAD, 0, 0, 1'b0);
        run_q();

        check_int("RETIRE_COUNT", cpi.size(), 10);
        for (int i = 0; i < 10 && i < cpi.size(); i++)
            check_int($sformatf("CPI_%0d", i), cpi[i], exp_cpi[i]);

        async_reset("TRAP_RESET");

        // Interrupt a stalled store, then confirm the FSM restarts cleanly.
        push_reset();
        instr(IT, 1, 0, 1'b0);
        fetch(SW, 0);
        alu_step(SW, "DECODE", 2'b01, 2'b01, 2'b00);
        alu_step(SW, "MEMADR", 2'b10, 2'b01, 2'b00);
        mem_access(SW, "MEMWRITE", 1, 1'b0);
        void'(q.pop_back());
        run_q();
        async_reset("MIDSW_RESET");

        push_reset();
        instr(LW, 1, 1, 1'b0);
        instr(BQ, 0, 0, 1'b1);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
